mipi_img_sync_chk: RTL

//  Downstream of the CSI-2 packet decoder on img_clk. Consumes its pixel stream (dat/dv/lv/fv) and

---
 rtl/mipi_img_pkg.sv | 31 +++
 rtl/mipi_sat_cnt.sv | 44 ++++
 rtl/mipi_img_sync_chk.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_img_pkg.sv
// mipi_img_pkg
//   Shared definitions for the MIPI image sync checker: FSM state encoding,
//   sticky-error bit indices and default widths.
package mipi_img_pkg;

  localparam int DATA_WIDTH_DEF = 10;
  localparam int PIX_W_DEF      = 16;
  localparam int LINE_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_FRAME      = 2'd1,
    ST_LINE       = 2'd2
  } state_t;

  // Bit positions inside the sticky error vector.
  localparam int ERR_WIDTH  = 0;
  localparam int ERR_HEIGHT = 1;
  localparam int ERR_PROTO  = 2;
  localparam int ERR_N      = 3;

  // Sticky update: a new error in the same cycle as a clear survives.
  function automatic logic [ERR_N-1:0] err_update(
    input logic [ERR_N-1:0] cur,
    input logic [ERR_N-1:0] set,
    input logic             clr
  );
    return (cur & ~{ERR_N{clr}}) | set;
  endfunction

endpackage

// File: rtl/mipi_sat_cnt.sv
// mipi_sat_cnt
//   Saturating up-counter with synchronous clear. Clear and increment in the
//   same cycle load 1, so a count can restart on the very cycle it is cleared.
//   Only the value the counter takes at the next edge is exposed: that is what
//   the closing logic in the checker needs (it includes the current increment).
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at 0
//   inc        : add one, holding at all-ones
//   val_nxt    : value the counter will hold after this edge
module mipi_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] val_nxt
);

  logic [W-1:0] cnt;

  // NOTE: combinational blocks assign every output a default first, so no
  // path through the block leaves a value unassigned and infers a latch.
  always_comb begin
    logic [W-1:0] base;
    base    = clr ? {W{1'b0}} : cnt;
    val_nxt = base;
    if (inc && (base != {W{1'b1}})) begin
      val_nxt = base + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in the simulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= val_nxt;
    end
  end

endmodule

// File: rtl/mipi_img_sync_chk.sv
// mipi_img_sync_chk
//   Sits behind the CSI-2 packet decoder on img_clk. Measures frame geometry
//   (pixels per line, lines per frame) against programmed values, raises sticky
//   errors and re-emits a clean, frame-aligned stream one cycle later. Frames
//   already in progress at reset release or enable are dropped.
// Ports
//   img_clk, resetb          : pixel clock, asynchronous active-low reset
//   enable                   : 0 gates the output valids and aborts the frame
//   dati, dvi, lvi, fvi      : pixel stream from the decoder
//   exp_width, exp_height    : expected geometry, 0 disables that check
//   clr_err                  : synchronous clear of the sticky errors
//   dato, dvo, lvo, fvo      : stream delayed one cycle, valids gated
//   meas_width, meas_height  : geometry of the last completed frame
//   frame_done               : one-cycle pulse per closed frame
//   err_width/height/proto   : sticky error flags
// Configuration
//   MIPI_IMG_CHK_STATS_EN : adds frame_cnt / bad_frame_cnt statistics outputs.
module mipi_img_sync_chk
  import mipi_img_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int LINE_W     = LINE_W_DEF
) (
  input  logic                  img_clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] dati,
  input  logic                  dvi,
  input  logic                  lvi,
  input  logic                  fvi,
  input  logic [PIX_W-1:0]      exp_width,
  input  logic [LINE_W-1:0]     exp_height,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dato,
  output logic                  dvo,
  output logic                  lvo,
  output logic                  fvo,
  output logic [PIX_W-1:0]      meas_width,
  output logic [LINE_W-1:0]     meas_height,
  output logic                  frame_done,
  output logic                  err_width,
  output logic                  err_height,
  output logic                  err_proto
`ifdef MIPI_IMG_CHK_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           bad_frame_cnt
`endif
);

  state_t state, state_nxt;

  logic lvi_q, fvi_q;
  // fvi_q resets to 0, so a frame already running at reset release would look
  // like a rising edge. Rises only count once fvi has been seen low.
  logic fv_armed;
  logic fv_rise, fv_fall, lv_rise, lv_fall;

  logic pix_clr, pix_inc, line_clr, line_close, frame_close, frame_start;
  logic [PIX_W-1:0]  pix_nxt;
  logic [LINE_W-1:0] line_nxt;

  logic [ERR_N-1:0] err_q, err_set;
  logic             pass;

  assign fv_rise = fvi & ~fvi_q & fv_armed;
  assign fv_fall = ~fvi & fvi_q;
  assign lv_rise = lvi & ~lvi_q;
  assign lv_fall = ~lvi & lvi_q;

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  mipi_sat_cnt #(.W(PIX_W)) u_pix_cnt (
    .clk     (img_clk),
    .rst_n   (resetb),
    .clr     (pix_clr),
    .inc     (pix_inc),
    .val_nxt (pix_nxt)
  );

  mipi_sat_cnt #(.W(LINE_W)) u_line_cnt (
    .clk     (img_clk),
    .rst_n   (resetb),
    .clr     (line_clr),
    .inc     (line_close),
    .val_nxt (line_nxt)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      state    <= ST_WAIT_FRAME;
      lvi_q    <= 1'b0;
      fvi_q    <= 1'b0;
      fv_armed <= 1'b0;
    end else begin
      state    <= state_nxt;
      lvi_q    <= lvi;
      fvi_q    <= fvi;
      fv_armed <= fv_armed | ~fvi;
    end
  end

  always_comb begin
    state_nxt   = state;
    pix_clr     = 1'b0;
    pix_inc     = 1'b0;
    line_clr    = 1'b0;
    line_close  = 1'b0;
    frame_close = 1'b0;
    frame_start = 1'b0;
    case (state)
      ST_WAIT_FRAME: begin
        pix_clr  = 1'b1;
        line_clr = 1'b1;
        if (enable && fv_rise) begin
          frame_start = 1'b1;
          // A line starting together with the frame is not missed.
          if (lvi) begin
            pix_inc   = dvi;
            state_nxt = ST_LINE;
          end else begin
            state_nxt = ST_FRAME;
          end
        end
      end
      ST_FRAME: begin
        if (fv_fall) begin
          frame_close = 1'b1;
          state_nxt   = ST_WAIT_FRAME;
        end else if (lv_rise) begin
          pix_clr   = 1'b1;
          pix_inc   = dvi;
          state_nxt = ST_LINE;
        end
      end
      ST_LINE: begin
        pix_inc = lvi & dvi;
        // A frame end always closes the open line first, so the height
        // check sees it whether or not lvi fell in the same cycle.
        if (fv_fall) begin
          line_close  = 1'b1;
          frame_close = 1'b1;
          state_nxt   = ST_WAIT_FRAME;
        end else if (lv_fall) begin
          line_close = 1'b1;
          state_nxt  = ST_FRAME;
        end
      end
      default: state_nxt = ST_WAIT_FRAME;
    endcase
    // Disabling aborts the frame silently: no closes, no frame_done.
    if (!enable) begin
      state_nxt   = ST_WAIT_FRAME;
      line_close  = 1'b0;
      frame_close = 1'b0;
      frame_start = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Checks, sticky errors and measurements
  // ---------------------------------------------------------------------------
  always_comb begin
    err_set             = '0;
    err_set[ERR_WIDTH]  = line_close && (exp_width != '0) && (pix_nxt != exp_width);
    err_set[ERR_HEIGHT] = frame_close && (exp_height != '0) && (line_nxt != exp_height);
    // Covers both a line outside a frame and fvi falling under an open line.
    err_set[ERR_PROTO]  = lvi & ~fvi;
  end

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      err_q       <= '0;
      meas_width  <= '0;
      meas_height <= '0;
      frame_done  <= 1'b0;
    end else begin
      err_q      <= err_update(err_q, err_set, clr_err);
      frame_done <= frame_close;
      if (frame_close) begin
        meas_width  <= pix_nxt;
        meas_height <= line_nxt;
      end
    end
  end

  assign err_width  = err_q[ERR_WIDTH];
  assign err_height = err_q[ERR_HEIGHT];
  assign err_proto  = err_q[ERR_PROTO];

  // ---------------------------------------------------------------------------
  // Output pipe: the frame-start cycle itself passes through.
  // ---------------------------------------------------------------------------
  assign pass = enable && ((state != ST_WAIT_FRAME) || fv_rise);

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      dato <= '0;
      dvo  <= 1'b0;
      lvo  <= 1'b0;
      fvo  <= 1'b0;
    end else begin
      dato <= dati;
      dvo  <= dvi & pass;
      lvo  <= lvi & pass;
      fvo  <= fvi & pass;
    end
  end

`ifdef MIPI_IMG_CHK_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic frame_bad;
  logic frame_bad_now;

  // Per-frame flag, restarted at each frame start; the closing cycle's own
  // errors are folded in directly.
  assign frame_bad_now = frame_bad | (|err_set);

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      frame_bad     <= 1'b0;
      frame_cnt     <= '0;
      bad_frame_cnt <= '0;
    end else begin
      frame_bad <= frame_start ? 1'b0 : frame_bad_now;
      if (frame_close) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      bad_frame_cnt <= (clr_err ? 16'd0 : bad_frame_cnt)
                       + 16'(frame_close && frame_bad_now);
    end
  end
`endif

endmodule
